pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports clk and rst; all state updates occur on the rising edge of clk.
REQ-002 The block SHALL have the following parameters (name, default, meaning):
- FLUSH_SLOTS, 2: bubble cycles inserted after a taken branch, legal range 1-7.
- MEM_TIMEOUT, 15: consecutive mem_busy cycles before mem_err sets, legal range 1-255.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- id_rs / id_rt, in, 5 each: ID-stage source register numbers.
- id_use_rs / id_use_rt, in, 1 each: the ID instruction reads that source.
- ex_rd, in, 5: EX-stage destination register.
- ex_regwrite, in, 1: EX instruction writes ex_rd.
- ex_memread, in, 1: EX instruction is a load.
- mem_rd, in, 5: MEM-stage destination register.
- mem_regwrite, in, 1: MEM instruction writes mem_rd.
- branch_taken, in, 1: EX resolved a taken branch or jump.
- mem_busy, in, 1: data memory is not ready.
- pc_en, out, 1: PC load enable.
- ifid_en, out, 1: IF/ID register enable.
- idex_en, out, 1: ID/EX register enable.
- exmem_en, out, 1: EX/MEM register enable.
- ifid_flush, out, 1: IF/ID register load-zero.
- idex_flush, out, 1: ID/EX register load-zero (bubble).
- fwd_a / fwd_b, out, 2 each: registered operand-select codes for EX.
- mem_err, out, 1: sticky memory timeout flag.
- stall_cnt, out, 16: saturating count of stall cycles.

Function
REQ-004 The FSM SHALL have three states, RUN, FLUSH and MEMWAIT; the transitions are defined by REQ-005 to REQ-009.
REQ-005 load_use SHALL be true when ex_memread=1, ex_regwrite=1, ex_rd!=0, and either (id_use_rs=1 and id_rs==ex_rd) or (id_use_rt=1 and id_rt==ex_rd).
REQ-006 Per-cycle priority SHALL be: mem_busy, then branch_taken, then load_use.
REQ-007 In RUN:
- If mem_busy=1: all enables=0, both flushes=0, next state MEMWAIT.
- Else if branch_taken=1: pc_en=ifid_en=idex_en=exmem_en=1, ifid_flush=idex_flush=1, flush counter loads FLUSH_SLOTS-1, next state FLUSH (or RUN if FLUSH_SLOTS=1).
- Else if load_use=1: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1, next state RUN.
- Otherwise: all enables=1, flushes=0.
REQ-008 In FLUSH:
- If mem_busy=0: all enables=1, ifid_flush=idex_flush=1, load_use is ignored, and the counter decrements; when the counter is 0 the next state is RUN.
- If mem_busy=1: all enables=0, flushes=0, the counter holds, and the state stays FLUSH.
REQ-009 In MEMWAIT:
- While mem_busy=1: all enables=0, flushes=0.
- When mem_busy=0: the next state is RUN, and outputs that cycle are per the RUN rules.
REQ-010 A wait counter SHALL count consecutive mem_busy=1 cycles and clear when mem_busy=0; on reaching MEM_TIMEOUT, mem_err SHALL set and stay set until rst.
REQ-011 Forwarding SHALL use these codes: 00 = register file, 01 = MEM-stage result, 10 = WB-stage result.
REQ-012 fwd_a SHALL be computed from id_rs and fwd_b from id_rt:
- 01 if ex_regwrite=1, ex_rd!=0 and the rd matches.
- Else 10 if mem_regwrite=1, mem_rd!=0 and the rd matches.
- Else 00.
REQ-013 fwd_a/fwd_b SHALL register only on cycles where idex_en=1; they SHALL load 00 when idex_flush=1.
REQ-014 stall_cnt SHALL increment on each cycle with pc_en=0 and saturate at 16'hFFFF.

Reset
REQ-015 With rst=1 at a clock edge, the block SHALL enter RUN and clear the flush counter, the wait counter, fwd_a, fwd_b, mem_err and stall_cnt to 0.
REQ-016 During and after reset, outputs SHALL be per RUN decode of the current inputs; rst has priority over all other inputs, including mid-FLUSH and mid-MEMWAIT.

Verification
REQ-017 Load-use: ex_memread=1, ex_regwrite=1, ex_rd=5, id_rs=5, id_use_rs=1 -> exactly one cycle with pc_en=0, ifid_en=0, idex_flush=1, and stall_cnt increments by 1.
REQ-018 Register 0: ex_rd=0, load in EX, id_rs=0 -> no stall, and fwd_a=00 after the edge.
REQ-019 Branch: branch_taken=1 for one cycle with FLUSH_SLOTS=2 -> ifid_flush=idex_flush=1 for exactly 2 consecutive cycles, then RUN.
REQ-020 Simultaneous events: mem_busy=1 with branch_taken=1 -> freeze and MEMWAIT; on mem_busy=0 with branch_taken still 1 -> the flush sequence starts that cycle.
REQ-021 Timeout: mem_busy=1 for 15 cycles -> mem_err=1 after the 15th edge; mem_err stays 1 after mem_busy=0 and clears only on rst.
REQ-022 Forwarding and reset: ex_rd=mem_rd=7, both regwrite=1, id_rt=7 -> fwd_b=01 (EX priority); rst mid-FLUSH -> RUN, fwd=00, stall_cnt=0 next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flush bubbles, memory-wait
// freeze with sticky timeout, and registered EX operand-forwarding selects.
module pipe_hazard_ctrl #(
  parameter int FLUSH_SLOTS = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic [4:0]  mem_rd,
  input  logic        mem_regwrite,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        mem_err,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MEMWAIT = 2'd2
  } state_t;

  localparam logic [2:0]  FLUSH_LOAD  = 3'(FLUSH_SLOTS - 1);
  localparam logic [7:0]  TIMEOUT     = 8'(MEM_TIMEOUT);
  localparam logic [1:0]  FWD_RF      = 2'b00;
  localparam logic [1:0]  FWD_MEM     = 2'b01;
  localparam logic [1:0]  FWD_WB      = 2'b10;

  state_t      r_state;
  state_t      w_cur;
  state_t      w_next;
  logic [2:0]  r_flush_cnt;
  logic [2:0]  w_flush_cnt_nxt;
  logic [7:0]  r_wait_cnt;
  logic [1:0]  r_fwd_a;
  logic [1:0]  r_fwd_b;
  logic        r_mem_err;
  logic [15:0] r_stall_cnt;

  logic        w_load_use;
  logic [1:0]  w_fwd_a;
  logic [1:0]  w_fwd_b;
  logic        w_pc_en;
  logic        w_ifid_en;
  logic        w_idex_en;
  logic        w_exmem_en;
  logic        w_ifid_flush;
  logic        w_idex_flush;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (ex_regwrite && (ex_rd != 5'd0) && (ex_rd == src))
      return FWD_MEM;
    else if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == src))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  assign w_load_use = ex_memread && ex_regwrite && (ex_rd != 5'd0) &&
                      ((id_use_rs && (id_rs == ex_rd)) ||
                       (id_use_rt && (id_rt == ex_rd)));

  assign w_fwd_a = fwd_sel(id_rs);
  assign w_fwd_b = fwd_sel(id_rt);

  // Reset forces the RUN decode even before the state register has been cleared.
  assign w_cur = rst ? ST_RUN : r_state;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    w_pc_en         = 1'b1;
    w_ifid_en       = 1'b1;
    w_idex_en       = 1'b1;
    w_exmem_en      = 1'b1;
    w_ifid_flush    = 1'b0;
    w_idex_flush    = 1'b0;
    w_next          = w_cur;
    w_flush_cnt_nxt = r_flush_cnt;

    case (w_cur)
      ST_FLUSH: begin
        if (mem_busy) begin
          {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en} = 4'b0000;
        end else begin
          w_ifid_flush    = 1'b1;
          w_idex_flush    = 1'b1;
          w_flush_cnt_nxt = r_flush_cnt - 3'd1;
          if (r_flush_cnt <= 3'd1)
            w_next = ST_RUN;
        end
      end
      // MEMWAIT decodes exactly like RUN: busy keeps it frozen, and the first
      // ready cycle takes whatever RUN would do, including a pending branch.
      default: begin
        if (mem_busy) begin
          {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en} = 4'b0000;
          w_next = ST_MEMWAIT;
        end else if (branch_taken) begin
          w_ifid_flush    = 1'b1;
          w_idex_flush    = 1'b1;
          w_flush_cnt_nxt = FLUSH_LOAD;
          w_next          = (FLUSH_SLOTS == 1) ? ST_RUN : ST_FLUSH;
        end else if (w_load_use) begin
          w_pc_en      = 1'b0;
          w_ifid_en    = 1'b0;
          w_idex_flush = 1'b1;
          w_next       = ST_RUN;
        end else begin
          w_next = ST_RUN;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 3'd0;
      r_wait_cnt  <= 8'd0;
      r_fwd_a     <= FWD_RF;
      r_fwd_b     <= FWD_RF;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= 16'd0;
    end else begin
      r_state     <= w_next;
      r_flush_cnt <= w_flush_cnt_nxt;

      if (!mem_busy)
        r_wait_cnt <= 8'd0;
      else if (r_wait_cnt != TIMEOUT)
        r_wait_cnt <= r_wait_cnt + 8'd1;

      if (mem_busy && (r_wait_cnt >= TIMEOUT - 8'd1))
        r_mem_err <= 1'b1;

      if (w_idex_en) begin
        r_fwd_a <= w_idex_flush ? FWD_RF : w_fwd_a;
        r_fwd_b <= w_idex_flush ? FWD_RF : w_fwd_b;
      end

      if (!w_pc_en && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign pc_en      = w_pc_en;
  assign ifid_en    = w_ifid_en;
  assign idex_en    = w_idex_en;
  assign exmem_en   = w_exmem_en;
  assign ifid_flush = w_ifid_flush;
  assign idex_flush = w_idex_flush;
  assign fwd_a      = r_fwd_a;
  assign fwd_b      = r_fwd_b;
  assign mem_err    = r_mem_err;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: stalls, flushes, memory freeze/timeout,
// forwarding priority and reset behaviour, checked with immediate assertions.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
  logic        id_use_rs, id_use_rt, ex_regwrite, ex_memread, mem_regwrite;
  logic        branch_taken, mem_busy;
  logic        pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic        mem_err;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush}
  localparam logic [5:0] C_RUN    = 6'b111100;
  localparam logic [5:0] C_FREEZE = 6'b000000;
  localparam logic [5:0] C_FLUSH  = 6'b111111;
  localparam logic [5:0] C_LU     = 6'b001101;

  pipe_hazard_ctrl #(.FLUSH_SLOTS(2), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic [5:0] exp);
    check(tag, 32'({pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush}), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
    mem_rd = 5'd0; mem_regwrite = 1'b0;
    branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    check_ctl("reset_ctl", C_RUN);
    check("reset_stall", 32'(stall_cnt), 32'd0);
    check("reset_err", 32'(mem_err), 32'd0);
    check("reset_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    rst = 1'b0;

    // Plain forwarding: EX match on rs, MEM match on rt
    ex_rd = 5'd3; ex_regwrite = 1'b1; id_rs = 5'd3;
    mem_rd = 5'd4; mem_regwrite = 1'b1; id_rt = 5'd4;
    #1 check_ctl("fwd_ctl", C_RUN);
    tick();
    check("fwd_a_ex", 32'(fwd_a), 32'd1);
    check("fwd_b_mem", 32'(fwd_b), 32'd2);

    // Both stages write r7: EX wins
    idle();
    ex_rd = 5'd7; ex_regwrite = 1'b1; mem_rd = 5'd7; mem_regwrite = 1'b1;
    id_rt = 5'd7; id_rs = 5'd1;
    tick();
    check("fwd_b_prio", 32'(fwd_b), 32'd1);
    check("fwd_a_none", 32'(fwd_a), 32'd0);

    // Load-use on r5: exactly one stall cycle with a bubble
    idle();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    #1 check_ctl("lu_ctl", C_LU);
    tick();
    check("lu_stall", 32'(stall_cnt), 32'd1);
    check("lu_fwd_bubble", 32'(fwd_a), 32'd0);
    idle();
    #1 check_ctl("lu_release", C_RUN);
    tick();
    check("lu_stall_once", 32'(stall_cnt), 32'd1);

    // Same hazard but rs unused: no stall, forwarding still selects EX
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b0;
    #1 check_ctl("lu_unused", C_RUN);
    tick();
    check("lu_unused_fwd", 32'(fwd_a), 32'd1);

    // Load into r0 never stalls or forwards
    idle();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    #1 check_ctl("r0_ctl", C_RUN);
    tick();
    check("r0_fwd", 32'(fwd_a), 32'd0);
    check("r0_stall", 32'(stall_cnt), 32'd1);

    // Taken branch: two flush cycles; load-use ignored in the second
    idle();
    branch_taken = 1'b1;
    #1 check_ctl("br_cyc1", C_FLUSH);
    tick();
    idle();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    #1 check_ctl("br_cyc2", C_FLUSH);
    tick();
    check("br_fwd_flushed", 32'(fwd_a), 32'd0);
    idle();
    #1 check_ctl("br_done", C_RUN);
    tick();

    // mem_busy with branch: freeze, then flush starts when memory is ready
    mem_busy = 1'b1; branch_taken = 1'b1;
    #1 check_ctl("sim_freeze1", C_FREEZE);
    tick();
    #1 check_ctl("sim_freeze2", C_FREEZE);
    tick();
    check("sim_stall", 32'(stall_cnt), 32'd3);
    mem_busy = 1'b0;
    #1 check_ctl("sim_flush1", C_FLUSH);
    tick();
    branch_taken = 1'b0;
    mem_busy = 1'b1;
    #1 check_ctl("flush_busy_hold", C_FREEZE);
    tick();
    mem_busy = 1'b0;
    #1 check_ctl("sim_flush2", C_FLUSH);
    tick();
    #1 check_ctl("sim_done", C_RUN);
    check("sim_stall_total", 32'(stall_cnt), 32'd4);

    // Timeout after 15 consecutive busy cycles; sticky until reset
    mem_busy = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check("tmo_before", 32'(mem_err), 32'd0);
    tick();
    check("tmo_set", 32'(mem_err), 32'd1);
    mem_busy = 1'b0;
    #1 check_ctl("tmo_release", C_RUN);
    tick();
    check("tmo_sticky", 32'(mem_err), 32'd1);
    check("tmo_stall", 32'(stall_cnt), 32'd19);

    // Reset in the middle of a flush with forwarding inputs live
    ex_rd = 5'd3; ex_regwrite = 1'b1; id_rs = 5'd3;
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    rst = 1'b1;
    #1 check_ctl("rst_mid_flush", C_RUN);
    tick();
    check("rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);
    rst = 1'b0;
    idle();
    #1 check_ctl("rst_after", C_RUN);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
